// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encoding,
// instruction field codes, branch conditions and PSR bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM_ADDR  = 3'd3,
        MEM_LOAD  = 3'd4,
        MEM_STORE = 3'd5,
        BRANCH    = 3'd6
    } cpu_state_t;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    // ALU codes double as R-type ext values and immediate-form opcodes
    localparam logic [3:0] ALU_AND   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_ADD   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b1001;
    localparam logic [3:0] ALU_CMP   = 4'b1011;
    localparam logic [3:0] ALU_MOV   = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ   = 4'b0000;
    localparam logic [3:0] COND_NE   = 4'b0001;
    localparam logic [3:0] COND_CS   = 4'b0010;
    localparam logic [3:0] COND_CC   = 4'b0011;
    localparam logic [3:0] COND_GT   = 4'b0110;
    localparam logic [3:0] COND_LE   = 4'b0111;
    localparam logic [3:0] COND_FS   = 4'b1000;
    localparam logic [3:0] COND_FC   = 4'b1001;
    localparam logic [3:0] COND_LO   = 4'b1010;
    localparam logic [3:0] COND_HS   = 4'b1011;
    localparam logic [3:0] COND_UC   = 4'b1110;

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_N = 1;
    localparam int PSR_Z = 0;

    function automatic logic isAluCode(input logic [3:0] code);
        return code inside {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_CMP, ALU_MOV};
    endfunction

    function automatic logic setsFlags(input logic [3:0] code);
        return code inside {ALU_ADD, ALU_SUB, ALU_CMP};
    endfunction

    // Arithmetic immediates and branch displacements are signed; logic/move immediates are not
    function automatic logic signExtends(input logic [3:0] opcode);
        return opcode inside {ALU_ADD, ALU_SUB, ALU_CMP, OP_BCOND};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition field and the latched
// PSR onto a taken/not-taken decision.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       taken
);

    always_comb begin
        case (cond)
            COND_EQ: taken = psr[PSR_Z];
            COND_NE: taken = !psr[PSR_Z];
            COND_CS: taken = psr[PSR_C];
            COND_CC: taken = !psr[PSR_C];
            COND_GT: taken = psr[PSR_N];
            COND_LE: taken = !psr[PSR_N];
            COND_FS: taken = psr[PSR_F];
            COND_FC: taken = !psr[PSR_F];
            COND_LO: taken = psr[PSR_L];
            COND_HS: taken = !psr[PSR_L];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control unit: fetches into the IR, decodes fields, sequences the
// datapath strobes and selects per state, and owns the PSR flags.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              instr,
    input  logic [4:0]               flagsIn,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic [REG_WIDTH-1:0]     immediate,
    output logic [3:0]               aluOpCode,
    output logic                     instrType,
    output logic                     srcAddressRegEnable,
    output logic                     dstAddressRegEnable,
    output logic                     immediateRegEnable,
    output logic                     regWriteEnable,
    output logic                     regWriteSelect,
    output logic                     aluInputAMuxSelect,
    output logic                     aluInputBMuxSelect,
    output logic                     aluOutputRegEnable,
    output logic                     pcEnable,
    output logic [1:0]               pcSourceSelect,
    output logic                     memAddrSelect,
    output logic                     memWriteEnable,
    output logic [4:0]               flags
);

    cpu_state_t  stateReg;
    logic [15:0] irReg;
    logic [4:0]  psrReg;

    logic [15:0] decodeWord;
    logic [3:0]  opcode;
    logic [3:0]  ext;
    logic [3:0]  aluCode;
    logic        isRType;
    logic        isImmType;
    logic        isAlu;
    logic        isLoad;
    logic        isStore;
    logic        isJcond;
    logic        isBcond;
    logic        flagOp;
    logic        taken;

    // In DECODE the fresh memory word is decoded directly so the address and
    // immediate capture strobes see the new fields; afterwards the IR is used.
    assign decodeWord = (stateReg == DECODE) ? instr : irReg;
    assign opcode     = decodeWord[15:12];
    assign ext        = decodeWord[7:4];

    assign isRType   = (opcode == OP_RTYPE) && isAluCode(ext);
    assign isImmType = isAluCode(opcode);
    assign isAlu     = isRType || isImmType;
    assign isLoad    = (opcode == OP_MEM) && (ext == EXT_LOAD);
    assign isStore   = (opcode == OP_MEM) && (ext == EXT_STOR);
    assign isJcond   = (opcode == OP_MEM) && (ext == EXT_JCOND);
    assign isBcond   = (opcode == OP_BCOND);

    // Bcond computes PC + displacement through the ALU
    assign aluCode = (opcode == OP_RTYPE) ? ext : (isBcond ? ALU_ADD : opcode);
    assign flagOp  = isAlu && setsFlags(aluCode);

    assign regAddressA = decodeWord[8 +: REG_ADDR_BITS];
    assign regAddressB = decodeWord[0 +: REG_ADDR_BITS];
    assign immediate   = signExtends(opcode)
                       ? {{(REG_WIDTH-8){decodeWord[7]}}, decodeWord[7:0]}
                       : {{(REG_WIDTH-8){1'b0}}, decodeWord[7:0]};
    assign aluOpCode   = aluCode;
    assign instrType   = isImmType || isBcond;
    assign flags       = psrReg;

    cond_eval condEval (
        .psr   (psrReg),
        .cond  (decodeWord[11:8]),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= FETCH;
            irReg    <= '0;
            psrReg   <= '0;
        end else begin
            case (stateReg)
                FETCH: stateReg <= DECODE;
                DECODE: begin
                    irReg <= instr;
                    if (isAlu)
                        stateReg <= EXECUTE;
                    else if (isLoad)
                        stateReg <= MEM_ADDR;
                    else if (isStore)
                        stateReg <= MEM_STORE;
                    else if (isJcond || isBcond)
                        stateReg <= BRANCH;
                    else
                        stateReg <= FETCH;
                end
                EXECUTE: begin
                    if (flagOp)
                        psrReg <= flagsIn;
                    stateReg <= FETCH;
                end
                MEM_ADDR: stateReg <= MEM_LOAD;
                default:  stateReg <= FETCH;
            endcase
        end
    end

    always_comb begin
        srcAddressRegEnable = 1'b0;
        dstAddressRegEnable = 1'b0;
        immediateRegEnable  = 1'b0;
        regWriteEnable      = 1'b0;
        regWriteSelect      = 1'b0;
        aluInputAMuxSelect  = 1'b0;
        aluInputBMuxSelect  = 1'b0;
        aluOutputRegEnable  = 1'b0;
        pcEnable            = 1'b0;
        pcSourceSelect      = 2'd0;
        memAddrSelect       = 1'b0;
        memWriteEnable      = 1'b0;
        // Reset masks every strobe immediately, even mid-instruction
        if (!reset) begin
            case (stateReg)
                DECODE: begin
                    srcAddressRegEnable = 1'b1;
                    dstAddressRegEnable = 1'b1;
                    immediateRegEnable  = 1'b1;
                    pcEnable            = 1'b1;
                    pcSourceSelect      = 2'd0;
                end
                EXECUTE: begin
                    aluOutputRegEnable = 1'b1;
                    regWriteEnable     = (aluCode != ALU_CMP);
                    regWriteSelect     = 1'b0;
                    aluInputBMuxSelect = isImmType;
                end
                MEM_ADDR: memAddrSelect = 1'b1;
                MEM_LOAD: begin
                    memAddrSelect  = 1'b1;
                    regWriteSelect = 1'b1;
                    regWriteEnable = 1'b1;
                end
                MEM_STORE: begin
                    memAddrSelect  = 1'b1;
                    memWriteEnable = 1'b1;
                end
                BRANCH: begin
                    pcEnable = taken;
                    if (isBcond) begin
                        pcSourceSelect     = 2'd1;
                        aluInputAMuxSelect = 1'b1;
                        aluInputBMuxSelect = 1'b1;
                    end else begin
                        pcSourceSelect = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
